// File: rtl/cancel_mem_arbiter.sv
// Read-modify-write sequencer and round-robin arbiter in front of the
// per-client cancelled-orders counter memory, including the post-reset zero sweep.
module cancel_mem_arbiter #(
    parameter int ID_W   = 5,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ID_W-1:0]   a_client_id,
    input  logic [DATA_W-1:0] a_amount,
    output logic              a_done,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ID_W-1:0]   b_client_id,
    input  logic              b_clear,
    output logic              b_rsp_valid,
    output logic [DATA_W-1:0] b_rsp_data,
    output logic [ID_W-1:0]   mem_addr,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [1:0] S_INIT = 2'd0;
    localparam logic [1:0] S_IDLE = 2'd1;
    localparam logic [1:0] S_RD   = 2'd2;
    localparam logic [1:0] S_MOD  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ID_W-1:0]   cnt_q, cnt_d;
    logic              last_b_q, last_b_d;
    logic              port_b_q, port_b_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [DATA_W-1:0] amt_q, amt_d;
    logic              clr_q, clr_d;
    logic              a_done_q;
    logic              b_rsp_valid_q;
    logic [DATA_W-1:0] b_rsp_data_q;
    logic [DATA_W:0]   sum;
    logic              gnt_a, gnt_b;

    // On a tie, the port not served last time wins.
    assign gnt_a = a_valid & (~b_valid | last_b_q);
    assign gnt_b = b_valid & (~a_valid | ~last_b_q);

    assign a_ready = (state_q == S_IDLE) & gnt_a;
    assign b_ready = (state_q == S_IDLE) & gnt_b;
    assign busy    = (state_q != S_IDLE);

    assign a_done      = a_done_q;
    assign b_rsp_valid = b_rsp_valid_q;
    assign b_rsp_data  = b_rsp_data_q;

    assign sum = {1'b0, mem_rdata} + {1'b0, amt_q};

    always_comb begin
        mem_addr  = '0;
        mem_wr    = 1'b0;
        mem_wdata = '0;
        case (state_q)
            S_INIT: begin
                mem_addr = cnt_q;
                // Suppress the sweep write while reset is held.
                mem_wr   = rst_n;
            end
            S_RD: begin
                mem_addr = id_q;
            end
            S_MOD: begin
                mem_addr = id_q;
                if (!port_b_q) begin
                    mem_wr    = 1'b1;
                    mem_wdata = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
                end else if (clr_q) begin
                    mem_wr = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_b_d = last_b_q;
        port_b_d = port_b_q;
        id_d     = id_q;
        amt_d    = amt_q;
        clr_d    = clr_q;
        case (state_q)
            S_INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (a_ready | b_ready) begin
                    state_d  = S_RD;
                    port_b_d = b_ready;
                    last_b_d = b_ready;
                    id_d     = b_ready ? b_client_id : a_client_id;
                    amt_d    = a_amount;
                    clr_d    = b_clear;
                end
            end
            S_RD:    state_d = S_MOD;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_INIT;
            cnt_q         <= '0;
            last_b_q      <= 1'b1;
            port_b_q      <= 1'b0;
            id_q          <= '0;
            amt_q         <= '0;
            clr_q         <= 1'b0;
            a_done_q      <= 1'b0;
            b_rsp_valid_q <= 1'b0;
            b_rsp_data_q  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_b_q      <= last_b_d;
            port_b_q      <= port_b_d;
            id_q          <= id_d;
            amt_q         <= amt_d;
            clr_q         <= clr_d;
            a_done_q      <= (state_q == S_MOD) & ~port_b_q;
            b_rsp_valid_q <= (state_q == S_MOD) & port_b_q;
            if ((state_q == S_MOD) && port_b_q) begin
                b_rsp_data_q <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_cancel_mem_arbiter.sv
// Directed bench for cancel_mem_arbiter with a behavioural 32x16 memory
// providing one-cycle registered read data.
module tb_cancel_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_client_id;
    logic [15:0] a_amount;
    logic        a_done;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_client_id;
    logic        b_clear;
    logic        b_rsp_valid;
    logic [15:0] b_rsp_data;
    logic [4:0]  mem_addr;
    logic        mem_wr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy;

    logic [15:0] mem [32];

    int n_cmp;
    int n_bad;

    typedef struct {
        bit          is_b;
        logic [4:0]  id;
        logic [15:0] amt;
        bit          clr;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [19];

    cancel_mem_arbiter dut (
        .clk(clk),
        .rst_n(rst_n),
        .a_valid(a_valid),
        .a_ready(a_ready),
        .a_client_id(a_client_id),
        .a_amount(a_amount),
        .a_done(a_done),
        .b_valid(b_valid),
        .b_ready(b_ready),
        .b_client_id(b_client_id),
        .b_clear(b_clear),
        .b_rsp_valid(b_rsp_valid),
        .b_rsp_data(b_rsp_data),
        .mem_addr(mem_addr),
        .mem_wr(mem_wr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input bit is_b, input logic [4:0] id,
                          input logic [15:0] amt, input bit clr,
                          output logic [15:0] rsp);
        int w;
        bit got;
        rsp = 16'hxxxx;
        got = 1'b0;
        @(negedge clk);
        if (is_b) begin
            b_valid = 1'b1; b_client_id = id; b_clear = clr;
        end else begin
            a_valid = 1'b1; a_client_id = id; a_amount = amt;
        end
        for (w = 0; w < 64; w++) begin
            #1;
            if (is_b ? b_ready : a_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("handshake", {31'd0, got}, 32'd1);
        if (!got) begin
            a_valid = 1'b0; b_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        a_client_id = 5'h1F; a_amount = 16'hDEAD; b_client_id = 5'h1F;
        chk("pulse_n1", {30'd0, a_done, b_rsp_valid}, 32'd0);
        @(negedge clk);
        chk("pulse_n2", {30'd0, a_done, b_rsp_valid}, 32'd0);
        @(negedge clk);
        chk("pulse_n3", {30'd0, a_done, b_rsp_valid},
            is_b ? 32'd1 : 32'd2);
        chk("idle_n3", {31'd0, busy}, 32'd0);
        if (is_b) rsp = b_rsp_data;
    endtask

    initial begin
        logic [15:0] r;
        n_cmp = 0;
        n_bad = 0;
        a_valid = 1'b0; a_client_id = '0; a_amount = '0;
        b_valid = 1'b0; b_client_id = '0; b_clear = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 16'hA5A5;

        vecs[0]  = '{1'b0, 5'h01, 16'h0001, 1'b0, 16'h0000};
        vecs[1]  = '{1'b1, 5'h01, 16'h0000, 1'b0, 16'h0001};
        vecs[2]  = '{1'b0, 5'h1B, 16'h00C5, 1'b0, 16'h0000};
        vecs[3]  = '{1'b0, 5'h1B, 16'h05C5, 1'b0, 16'h0000};
        vecs[4]  = '{1'b1, 5'h1B, 16'h0000, 1'b0, 16'h068A};
        vecs[5]  = '{1'b1, 5'h1B, 16'h0000, 1'b1, 16'h068A};
        vecs[6]  = '{1'b1, 5'h1B, 16'h0000, 1'b0, 16'h0000};
        vecs[7]  = '{1'b0, 5'h02, 16'hF000, 1'b0, 16'h0000};
        vecs[8]  = '{1'b0, 5'h02, 16'hF000, 1'b0, 16'h0000};
        vecs[9]  = '{1'b1, 5'h02, 16'h0000, 1'b0, 16'hFFFF};
        vecs[10] = '{1'b0, 5'h02, 16'h0001, 1'b0, 16'h0000};
        vecs[11] = '{1'b1, 5'h02, 16'h0000, 1'b0, 16'hFFFF};
        vecs[12] = '{1'b0, 5'h04, 16'hFFFE, 1'b0, 16'h0000};
        vecs[13] = '{1'b0, 5'h04, 16'h0001, 1'b0, 16'h0000};
        vecs[14] = '{1'b1, 5'h04, 16'h0000, 1'b0, 16'hFFFF};
        vecs[15] = '{1'b0, 5'h03, 16'h0000, 1'b0, 16'h0000};
        vecs[16] = '{1'b1, 5'h03, 16'h0000, 1'b0, 16'h0000};
        vecs[17] = '{1'b1, 5'h10, 16'h0000, 1'b0, 16'h0002};
        vecs[18] = '{1'b1, 5'h11, 16'h0000, 1'b0, 16'h0000};

        rst_n = 1'b0;
        a_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_mem", {mem_addr, mem_wr, mem_wdata}, 32'd0);
        chk("rst_rsp", {b_rsp_data, a_done, b_rsp_valid}, 32'd0);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            if (i > 0) @(negedge clk);
            chk("sweep", {a_ready, mem_wr, mem_addr, mem_wdata},
                {16'd0, 1'b0, 1'b1, i[4:0], 16'h0000});
        end
        @(negedge clk);
        chk("init_end", {30'd0, busy, a_ready}, 32'd1);
        a_valid = 1'b0;

        for (int i = 0; i < 32; i++) begin
            run_op(1'b1, i[4:0], 16'h0, 1'b0, r);
            chk("zero_rd", {16'd0, r}, 32'd0);
        end

        @(negedge clk);
        a_valid = 1'b1; a_client_id = 5'h10; a_amount = 16'h0001;
        b_valid = 1'b1; b_client_id = 5'h11; b_clear = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            chk("arb", {30'd0, a_ready, b_ready},
                {30'd0, c % 6 == 0, c % 6 == 3});
        end
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;
        chk("arb_last_rsp", {30'd0, a_done, b_rsp_valid}, 32'd1);

        foreach (vecs[i]) begin
            run_op(vecs[i].is_b, vecs[i].id, vecs[i].amt, vecs[i].clr, r);
            if (vecs[i].is_b) chk("vec_rsp", {16'd0, r}, {16'd0, vecs[i].exp});
        end

        run_op(1'b0, 5'h05, 16'h1234, 1'b0, r);
        run_op(1'b1, 5'h05, 16'h0, 1'b0, r);
        chk("pre_rst_rd", {16'd0, r}, 32'h1234);
        @(negedge clk);
        a_valid = 1'b1; a_client_id = 5'h05; a_amount = 16'h0100;
        #1;
        chk("mid_hs", {31'd0, a_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        @(negedge clk);
        chk("mid_mod_wr", {31'd0, mem_wr}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr", {30'd0, mem_wr, busy}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_no_done", {30'd0, a_done, mem_wr}, 32'd0);
        end
        rst_n = 1'b1;
        #1;
        chk("resweep0", {26'd0, mem_wr, mem_addr}, {26'd0, 1'b1, 5'd0});
        repeat (32) @(negedge clk);
        chk("resweep_end", {31'd0, busy}, 32'd0);
        run_op(1'b1, 5'h05, 16'h0, 1'b0, r);
        chk("post_rst_rd", {16'd0, r}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cancel_mem_arbiter.md
# cancel_mem_arbiter

Sequencer and arbiter for the per-client cancelled-orders counter memory (32 entries × 16 bit). Two requesters share the single memory port:
- Port A: downstream cancel feed. Adds the cancelled amount to a client's counter.
- Port B: query/clear path. Reads a client's counter, optionally read-and-clear.

The block owns the read-modify-write sequencing, round-robin arbitration and the post-reset zeroing sweep. The memory itself sits outside this block.

## Interface

- ID_W, 5, client_id width; memory depth is 2**ID_W
- DATA_W, 16, counter and amount width

- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- a_valid  in  1  port A request
- a_ready  out  1  port A accept; handshake = a_valid & a_ready
- a_client_id  in  ID_W  port A client
- a_amount  in  DATA_W  amount to add
- a_done  out  1  one-cycle pulse, port A op committed
- b_valid  in  1  port B request
- b_ready  out  1  port B accept
- b_client_id  in  ID_W  port B client
- b_clear  in  1  1 = read-and-clear, 0 = read only
- b_rsp_valid  out  1  one-cycle pulse, b_rsp_data valid
- b_rsp_data  out  DATA_W  counter value before the op
- mem_addr  out  ID_W  memory address
- mem_wr  out  1  memory write strobe
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  read data, valid the cycle after mem_addr is presented with mem_wr=0
- busy  out  1  high in every state except IDLE

## Operation

- FSM states: INIT, IDLE, RD, MOD.
- INIT:
  - Entered on reset.
  - Sweep counter runs 0..2**ID_W-1. Each cycle drives mem_wr=1, mem_addr=counter, mem_wdata=0.
  - After the last address, go to IDLE (32 cycles for the defaults).
  - a_ready = b_ready = 0 throughout.
- IDLE, arbitration:
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid: grant the port not granted last. The last-grant register resets to B, so A wins the first tie.
  - a_ready/b_ready are asserted only in IDLE, only for the granted port, and only while that port's valid is high (combinational from valid and state).
  - On handshake: capture port, client_id, amount/clear into registers, then go to RD. Requester inputs may change freely afterwards.
  - No valid: stay in IDLE.
- RD: mem_addr = captured id, mem_wr=0. Go to MOD.
- MOD: mem_addr = captured id, old = mem_rdata.
  - Port A: mem_wr=1, mem_wdata = old + amount, saturating at 2**DATA_W-1 (no wrap). amount=0 still writes old.
  - Port B, clear=1: mem_wr=1, mem_wdata=0.
  - Port B, clear=0: mem_wr=0.
  - Register the response (A: a_done; B: b_rsp_valid and b_rsp_data=old). Go to IDLE.
- Addition is performed DATA_W+1 wide. The carry bit selects the saturated value.

## Timing

- Reset values:
  - a_ready=0, b_ready=0, a_done=0, b_rsp_valid=0, b_rsp_data=0, busy=1.
  - mem_addr=0, mem_wr=0, mem_wdata=0, state=INIT, sweep counter=0, last-grant=B.
- Reset is asynchronous. Asserting rst_n mid-operation (RD or MOD) drops the in-flight request: no done/response pulse, and a partial write does not occur after reset assertion. The INIT sweep then restarts from address 0.
- Latency, with the handshake at cycle n:
  - RD at n+1.
  - Write at n+2.
  - a_done / b_rsp_valid high for exactly cycle n+3, which is IDLE.
  - A new handshake may occur in that same cycle n+3.
- Throughput: one operation per 3 cycles.
- Back-to-back ops to the same client need no forwarding: the write at n+2 precedes the next read at n+4 or later.
- A requester holding valid is served within 2 operations (round-robin bound).

## Test plan

- Reset, then wait: mem_wr=1 for 32 consecutive cycles with mem_addr 0..31 and wdata 0. a_ready held 0 until IDLE. Afterwards, a B read of every id returns 0.
- A add, id=0x01, amount=0x0001, then B read id=0x01: b_rsp_data=0x0001, with a_done exactly 3 cycles after the A handshake.
- A add id=0x1B amount 0x00C5, then 0x05C5: B read returns 0x068A. B read-and-clear returns 0x068A, a following B read returns 0x0000.
- Saturation: id=0x02 twice with amount 0xF000 → counter 0xFFFF; a further add of 0x0001 leaves it at 0xFFFF.
- Both valid continuously after INIT: grants alternate A, B, A, B. Each ready pulses 1 cycle per grant, and handshakes are spaced 3 cycles apart.
- Assert rst_n low during MOD of an A add to id 0x05: no a_done, INIT sweep restarts at address 0, and a subsequent read of 0x05 returns 0.
